// File: rtl/idelaye3_iserdese3_pkg.sv
// Shared definitions for the delay-line plus deserialiser block:
// parameter defaults, legal-width check and the delay-counter width.
package idelaye3_iserdese3_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MAX_DELAY  = 31;

  typedef enum logic [1:0] {
    DLY_HOLD,
    DLY_LOAD,
    DLY_INC,
    DLY_DEC
  } dly_op_e;

  function automatic int cnt_w(input int max_delay);
    return (max_delay < 1) ? 1 : $clog2(max_delay + 1);
  endfunction

  function automatic bit width_ok(input int w);
    return (w == 4) || (w == 8);
  endfunction

endpackage

// File: rtl/idelaye3_iserdese3_delay_line.sv
// Programmable delay line: saturating tap setting plus a shift register
// whose tap is muxed onto d_dly (setting 0 bypasses the register).
module idelaye3_iserdese3_delay_line
  import idelaye3_iserdese3_pkg::*;
#(
  parameter int DELAY_VALUE = 0,
  parameter int MAX_DELAY   = DEF_MAX_DELAY,
  localparam int CNT_W      = cnt_w(MAX_DELAY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d,
  input  logic             load,
  input  logic [CNT_W-1:0] cntvaluein,
  input  logic             ce,
  input  logic             inc,
  output logic [CNT_W-1:0] cntvalueout,
  output logic             d_dly
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_DELAY);
  localparam logic [CNT_W-1:0] RST_C =
    (DELAY_VALUE >= MAX_DELAY) ? MAX_C : CNT_W'(DELAY_VALUE);

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [MAX_DELAY-1:0] dl_q, dl_d;
  logic                 d_tap;
  dly_op_e              op;

  always_comb begin
    op = DLY_HOLD;
    if (load) begin
      op = DLY_LOAD;
    end else if (ce) begin
      op = inc ? DLY_INC : DLY_DEC;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case (op)
      DLY_LOAD: cnt_d = (cntvaluein > MAX_C) ? MAX_C : cntvaluein;
      DLY_INC:  cnt_d = (cnt_q == MAX_C) ? cnt_q : cnt_q + 1'b1;
      DLY_DEC:  cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
      default:  cnt_d = cnt_q;
    endcase
  end

  // dl_q[i] holds d as sampled i+1 edges ago; contents survive setting changes.
  always_comb begin
    dl_d[0] = d;
    for (int i = 1; i < MAX_DELAY; i++) begin
      dl_d[i] = dl_q[i-1];
    end
  end

  always_comb begin
    d_tap = 1'b0;
    for (int i = 0; i < MAX_DELAY; i++) begin
      if (cnt_q == CNT_W'(i + 1)) begin
        d_tap = dl_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= RST_C;
      dl_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      dl_q  <= dl_d;
    end
  end

  assign cntvalueout = cnt_q;
  assign d_dly       = (cnt_q == '0) ? d : d_tap;

endmodule

// File: rtl/idelaye3_iserdese3.sv
// Delay line feeding an MSB-first deserialiser with bitslip word alignment.
// q updates once per DATA_WIDTH bits and is strobed by q_valid.
module idelaye3_iserdese3
  import idelaye3_iserdese3_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int DELAY_VALUE = 0,
  parameter int MAX_DELAY   = DEF_MAX_DELAY,
  localparam int CNT_W      = cnt_w(MAX_DELAY)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  d,
  input  logic                  load,
  input  logic [CNT_W-1:0]      cntvaluein,
  input  logic                  ce,
  input  logic                  inc,
  input  logic                  bitslip,
  output logic [CNT_W-1:0]      cntvalueout,
  output logic                  d_dly,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  q_valid
);

  generate
    if (!width_ok(DATA_WIDTH)) begin : g_bad_width
      $error("idelaye3_iserdese3: DATA_WIDTH must be 4 or 8");
    end
  endgenerate

  localparam int              BC_W = $clog2(DATA_WIDTH);
  localparam logic [BC_W-1:0] LAST = BC_W'(DATA_WIDTH - 1);

  logic                  dly_bit;
  logic [DATA_WIDTH-2:0] hist_q, hist_d;
  logic [DATA_WIDTH-1:0] word;
  logic [BC_W-1:0]       bitcnt_q, bitcnt_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  valid_q, valid_d;
  logic                  word_done;

  idelaye3_iserdese3_delay_line #(
    .DELAY_VALUE (DELAY_VALUE),
    .MAX_DELAY   (MAX_DELAY)
  ) u_delay_line (
    .clk         (clk),
    .rst_n       (rst_n),
    .d           (d),
    .load        (load),
    .cntvaluein  (cntvaluein),
    .ce          (ce),
    .inc         (inc),
    .cntvalueout (cntvalueout),
    .d_dly       (dly_bit)
  );

  // The word includes the bit being sampled at this edge.
  assign word      = {hist_q, dly_bit};
  assign word_done = (bitcnt_q == LAST) && !bitslip;

  always_comb begin
    hist_d   = word[DATA_WIDTH-2:0];
    bitcnt_d = bitcnt_q;
    if (!bitslip) begin
      bitcnt_d = (bitcnt_q == LAST) ? '0 : bitcnt_q + 1'b1;
    end
    word_d  = word_done ? word : word_q;
    valid_d = word_done;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q   <= '0;
      bitcnt_q <= '0;
      word_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      hist_q   <= hist_d;
      bitcnt_q <= bitcnt_d;
      word_q   <= word_d;
      valid_q  <= valid_d;
    end
  end

  assign d_dly   = dly_bit;
  assign q       = word_q;
  assign q_valid = valid_q;

endmodule

// File: tb/tb_idelaye3_iserdese3.sv
// Directed bench: zero-delay, 8-cycle-delay and reduced-range instances
// share one clock, reset and serial stream.
module tb_idelaye3_iserdese3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       d = 1'b0;
  logic       load = 1'b0;
  logic [4:0] cntvaluein = '0;
  logic       ce = 1'b0;
  logic       inc = 1'b0;
  logic       bitslip = 1'b0;
  logic       ld_m = 1'b0;
  logic [4:0] val_m = '0;
  logic       ce_m = 1'b0;
  logic       inc_m = 1'b0;

  logic [4:0] cnt0, cnt8, cntm;
  logic       dly0, dly8, dlym;
  logic [7:0] q0, q8, qm;
  logic       qv0, qv8, qvm;

  int nvec = 0;
  int nmis = 0;
  int cyc = 0;
  int p0;
  int q0_cyc[$];
  logic [7:0] q0_val[$];
  int q8_cyc[$];
  logic [7:0] q8_val[$];

  always #5 clk = ~clk;

  idelaye3_iserdese3 #(.DATA_WIDTH(8), .DELAY_VALUE(0), .MAX_DELAY(31)) u_d0 (
    .clk(clk), .rst_n(rst_n), .d(d), .load(load), .cntvaluein(cntvaluein),
    .ce(ce), .inc(inc), .bitslip(bitslip), .cntvalueout(cnt0),
    .d_dly(dly0), .q(q0), .q_valid(qv0)
  );

  idelaye3_iserdese3 #(.DATA_WIDTH(8), .DELAY_VALUE(8), .MAX_DELAY(31)) u_d8 (
    .clk(clk), .rst_n(rst_n), .d(d), .load(1'b0), .cntvaluein(5'd0),
    .ce(1'b0), .inc(1'b0), .bitslip(bitslip), .cntvalueout(cnt8),
    .d_dly(dly8), .q(q8), .q_valid(qv8)
  );

  // Range 0..20 so an out-of-range load value fits in the 5-bit port.
  idelaye3_iserdese3 #(.DATA_WIDTH(8), .DELAY_VALUE(3), .MAX_DELAY(20)) u_m20 (
    .clk(clk), .rst_n(rst_n), .d(d), .load(ld_m), .cntvaluein(val_m),
    .ce(ce_m), .inc(inc_m), .bitslip(1'b0), .cntvalueout(cntm),
    .d_dly(dlym), .q(qm), .q_valid(qvm)
  );

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (qv0) begin
      q0_cyc.push_back(cyc);
      q0_val.push_back(q0);
    end
    if (qv8) begin
      q8_cyc.push_back(cyc);
      q8_val.push_back(q8);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_q0(input int idx, input int ecyc, input logic [7:0] eval, input string tag);
    if (idx < q0_cyc.size()) begin
      chk($sformatf("%s_cyc%0d", tag, idx), q0_cyc[idx], ecyc);
      chk($sformatf("%s_val%0d", tag, idx), {24'd0, q0_val[idx]}, {24'd0, eval});
    end else begin
      chk($sformatf("%s_count", tag), q0_cyc.size(), idx + 1);
    end
  endtask

  task automatic chk_q8(input int idx, input int ecyc, input logic [7:0] eval, input string tag);
    if (idx < q8_cyc.size()) begin
      chk($sformatf("%s_cyc%0d", tag, idx), q8_cyc[idx], ecyc);
      chk($sformatf("%s_val%0d", tag, idx), {24'd0, q8_val[idx]}, {24'd0, eval});
    end else begin
      chk($sformatf("%s_count", tag), q8_cyc.size(), idx + 1);
    end
  endtask

  task automatic send_bit(input logic b, input logic bs);
    @(negedge clk);
    rst_n   = 1'b1;
    d       = b;
    bitslip = bs;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i], 1'b0);
  endtask

  // Leaves rst_n low; the next send_bit releases it together with bit 0.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    d = 1'b0;
    bitslip = 1'b0;
    repeat (2) @(negedge clk);
    q0_cyc.delete(); q0_val.delete();
    q8_cyc.delete(); q8_val.delete();
    p0 = cyc + 1;
  endtask

  task automatic ctl(input logic ld, input logic [4:0] v, input logic c, input logic i);
    @(negedge clk);
    load = ld; cntvaluein = v; ce = c; inc = i;
    @(posedge clk);
    #1;
    load = 1'b0; ce = 1'b0; inc = 1'b0;
  endtask

  task automatic ctl_m(input logic ld, input logic [4:0] v, input logic c, input logic i);
    @(negedge clk);
    ld_m = ld; val_m = v; ce_m = c; inc_m = i;
    @(posedge clk);
    #1;
    ld_m = 1'b0; ce_m = 1'b0; inc_m = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;
    int exp_c;

    // Reset state.
    do_reset();
    chk("rst_q0", {24'd0, q0}, 32'h0);
    chk("rst_qv0", {31'd0, qv0}, 32'd0);
    chk("rst_cnt0", {27'd0, cnt0}, 32'd0);
    chk("rst_cnt8", {27'd0, cnt8}, 32'd8);
    chk("rst_cntm", {27'd0, cntm}, 32'd3);

    // Six 0x5A words then 0x69 words; the delay-8 copy lags by one word.
    for (int r = 0; r < 6; r++) send_byte(8'h5A);
    for (int r = 0; r < 3; r++) send_byte(8'h69);
    send_byte(8'h00);
    @(posedge clk);
    #2;
    for (int i = 0; i < 9; i++)
      chk_q0(i, p0 + 8 * (i + 1), (i < 6) ? 8'h5A : 8'h69, "p1_d0");
    // First delay-8 strobe carries only the cleared delay line.
    chk_q8(0, p0 + 8, 8'h00, "p1_d8");
    for (int i = 1; i < 10; i++)
      chk_q8(i, p0 + 8 * (i + 1), (i - 1 < 6) ? 8'h5A : 8'h69, "p1_d8");

    // Bitslip on the 28th bit delays the 4th word by one cycle and realigns it.
    do_reset();
    pat = 8'h5A;
    for (int n = 0; n < 56; n++) send_bit(pat[7 - (n % 8)], n == 27);
    @(posedge clk);
    #2;
    chk_q0(0, p0 + 8,  8'h5A, "p2");
    chk_q0(1, p0 + 16, 8'h5A, "p2");
    chk_q0(2, p0 + 24, 8'h5A, "p2");
    chk_q0(3, p0 + 33, 8'hB4, "p2");
    chk_q0(4, p0 + 41, 8'hB4, "p2");
    chk_q0(5, p0 + 49, 8'hB4, "p2");

    // Delay-setting saturation.
    ctl(1'b1, 5'd30, 1'b0, 1'b0);
    chk("ld30", {27'd0, cnt0}, 32'd30);
    for (int k = 0; k < 3; k++) begin
      ctl(1'b0, 5'd0, 1'b1, 1'b1);
      chk($sformatf("inc%0d", k), {27'd0, cnt0}, 32'd31);
    end
    for (int k = 1; k <= 33; k++) begin
      ctl(1'b0, 5'd0, 1'b1, 1'b0);
      exp_c = (31 - k < 0) ? 0 : 31 - k;
      chk($sformatf("dec%0d", k), {27'd0, cnt0}, exp_c);
    end
    ctl_m(1'b1, 5'd25, 1'b0, 1'b0);
    chk("m_ld25", {27'd0, cntm}, 32'd20);
    ctl_m(1'b0, 5'd0, 1'b1, 1'b1);
    chk("m_inc_sat", {27'd0, cntm}, 32'd20);
    ctl_m(1'b0, 5'd0, 1'b1, 1'b0);
    chk("m_dec", {27'd0, cntm}, 32'd19);

    // Load wins over ce.
    ctl(1'b1, 5'd5, 1'b1, 1'b1);
    chk("ld_ce", {27'd0, cnt0}, 32'd5);

    // A single 1 must appear on d_dly exactly 5 edges later.
    @(negedge clk);
    d = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      #1;
      d = 1'b0;
      chk($sformatf("dly5_%0d", k), {31'd0, dly0}, (k == 4) ? 32'd1 : 32'd0);
    end

    // Reset mid-word discards the partial word and restores DELAY_VALUE.
    for (int n = 0; n < 5; n++) send_bit(1'b1, 1'b0);
    do_reset();
    chk("mid_rst_cnt0", {27'd0, cnt0}, 32'd0);
    chk("mid_rst_q0", {24'd0, q0}, 32'h0);
    chk("mid_rst_qv0", {31'd0, qv0}, 32'd0);
    chk("mid_rst_cntm", {27'd0, cntm}, 32'd3);
    send_byte(8'h69);
    send_byte(8'h00);
    @(posedge clk);
    #2;
    chk_q0(0, p0 + 8, 8'h69, "p4");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
